// File: rtl/decoder_scan_ctrl.sv
// decoder_scan_ctrl
// Walks the select input of a 3-to-8 decoder through its codes. Each code is
// held for DWELL clock cycles. Four sequencing modes, start/stop control,
// registered status flags.
//
// state  | meaning
// -------+----------------------------------------------------------------
// S_IDLE | waiting for start; sel=0, sel_valid=0, busy=0
// S_RUN  | scanning; sel presented to the decoder, dwell counter running
// S_DONE | single up-pass finished; one-cycle done pulse, then back to IDLE
//
// mode | sequence
// -----+------------------------------------------------------------------
// 00   | up, continuous, wraps max->0 (wrap on the new 0)
// 01   | down, continuous, wraps 0->max (wrap on the new max)
// 10   | ping-pong 0..max..0, endpoints not repeated (wrap on each endpoint)
// 11   | one up-pass 0..max, then DONE

module decoder_scan_ctrl #(
   parameter int SEL_W = 3,
   parameter int DWELL = 50
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             stop,
   input  logic [1:0]       mode,
   output logic [SEL_W-1:0] sel,
   output logic             sel_valid,
   output logic             busy,
   output logic             wrap,
   output logic             done
);

   localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam logic [SEL_W-1:0] SEL_MAX = {SEL_W{1'b1}};
   localparam logic [SEL_W-1:0] SEL_MIN = '0;
   localparam logic [CNT_W-1:0] CNT_TC  = CNT_W'(DWELL - 1);

   localparam logic [1:0] MODE_UP   = 2'b00;
   localparam logic [1:0] MODE_DOWN = 2'b01;
   localparam logic [1:0] MODE_PING = 2'b10;
   localparam logic [1:0] MODE_ONCE = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_RUN  = 2'b01,
      S_DONE = 2'b10
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [1:0]       mode_q;
   logic             dir_up;

   logic [SEL_W-1:0] sel_inc;
   logic [SEL_W-1:0] sel_dec;
   logic             dwell_end;

   // Neighbour codes and end-of-dwell flag used by the advance rules.
   always_comb begin
      sel_inc   = sel + SEL_W'(1);
      sel_dec   = sel - SEL_W'(1);
      dwell_end = (cnt == CNT_TC);
   end

   // Sequencer FSM with registered outputs; stop wins over any advance.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         cnt       <= '0;
         mode_q    <= MODE_UP;
         dir_up    <= 1'b1;
         sel       <= '0;
         sel_valid <= 1'b0;
         busy      <= 1'b0;
         wrap      <= 1'b0;
         done      <= 1'b0;
      end else begin
         wrap <= 1'b0;
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start && !stop) begin
                  state     <= S_RUN;
                  mode_q    <= mode;
                  dir_up    <= 1'b1;
                  sel       <= (mode == MODE_DOWN) ? SEL_MAX : SEL_MIN;
                  sel_valid <= 1'b1;
                  busy      <= 1'b1;
                  cnt       <= '0;
               end
            end

            S_RUN: begin
               if (stop) begin
                  state     <= S_IDLE;
                  sel       <= '0;
                  sel_valid <= 1'b0;
                  busy      <= 1'b0;
                  cnt       <= '0;
               end else if (dwell_end) begin
                  cnt <= '0;
                  case (mode_q)
                     MODE_UP: begin
                        sel  <= sel_inc;
                        wrap <= (sel == SEL_MAX);
                     end
                     MODE_DOWN: begin
                        sel  <= sel_dec;
                        wrap <= (sel == SEL_MIN);
                     end
                     MODE_PING: begin
                        if (dir_up) begin
                           sel <= sel_inc;
                           if (sel_inc == SEL_MAX) begin
                              dir_up <= 1'b0;
                              wrap   <= 1'b1;
                           end
                        end else begin
                           sel <= sel_dec;
                           if (sel_dec == SEL_MIN) begin
                              dir_up <= 1'b1;
                              wrap   <= 1'b1;
                           end
                        end
                     end
                     default: begin
                        // Single pass: the last code's dwell ends the scan and
                        // sel is left on max for the DONE cycle.
                        if (sel == SEL_MAX) begin
                           state     <= S_DONE;
                           sel_valid <= 1'b0;
                           busy      <= 1'b0;
                           done      <= 1'b1;
                        end else begin
                           sel <= sel_inc;
                        end
                     end
                  endcase
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end

            S_DONE: begin
               state <= S_IDLE;
               sel   <= '0;
            end

            default: begin
               state     <= S_IDLE;
               sel       <= '0;
               sel_valid <= 1'b0;
               busy      <= 1'b0;
               cnt       <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// Bench for decoder_scan_ctrl: four instances with DWELL 4, 2, 1 and 3 share
// one stimulus stream. A reference model, written in terms of a position in
// the scan sequence, predicts each instance's outputs when inputs are driven;
// predictions are queued and popped after the clock edge for comparison.

module tb_decoder_scan_ctrl;

   localparam int NI = 4;
   localparam int DW [NI] = '{4, 2, 1, 3};
   localparam int MX = 7;

   logic       clk;
   logic       rst;
   logic       start;
   logic       stop;
   logic [1:0] mode;

   logic [2:0] sel_o   [NI];
   logic       valid_o [NI];
   logic       busy_o  [NI];
   logic       wrap_o  [NI];
   logic       done_o  [NI];

   for (genvar g = 0; g < NI; g++) begin : g_dut
      decoder_scan_ctrl #(.SEL_W(3), .DWELL(DW[g])) u_dut (
         .clk       (clk),
         .rst       (rst),
         .start     (start),
         .stop      (stop),
         .mode      (mode),
         .sel       (sel_o[g]),
         .sel_valid (valid_o[g]),
         .busy      (busy_o[g]),
         .wrap      (wrap_o[g]),
         .done      (done_o[g])
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference model state (0 idle, 1 run, 2 done).
   int m_st   [NI];
   int m_pos  [NI];
   int m_cnt  [NI];
   int m_mode [NI];
   int m_sel  [NI];
   bit m_v [NI];
   bit m_b [NI];
   bit m_w [NI];
   bit m_d [NI];

   typedef struct {
      int         inst;
      logic [6:0] val;
   } exp_t;
   exp_t sb[$];

   function automatic int sel_of(int md, int pos);
      case (md)
         1:       return MX - pos;
         2:       return (pos <= MX) ? pos : (2 * MX - pos);
         default: return pos;
      endcase
   endfunction

   task automatic model_reset(int i);
      m_st[i] = 0; m_pos[i] = 0; m_cnt[i] = 0; m_mode[i] = 0; m_sel[i] = 0;
      m_v[i] = 0; m_b[i] = 0; m_w[i] = 0; m_d[i] = 0;
   endtask

   task automatic model_step(int i);
      m_w[i] = 0;
      m_d[i] = 0;
      if (rst) begin
         model_reset(i);
      end else if (m_st[i] == 0) begin
         if (start && !stop) begin
            m_st[i] = 1; m_mode[i] = int'(mode); m_pos[i] = 0; m_cnt[i] = 0;
            m_sel[i] = sel_of(m_mode[i], 0); m_v[i] = 1; m_b[i] = 1;
         end
      end else if (m_st[i] == 1) begin
         if (stop) begin
            m_st[i] = 0; m_sel[i] = 0; m_v[i] = 0; m_b[i] = 0; m_cnt[i] = 0;
         end else if (m_cnt[i] == DW[i] - 1) begin
            m_cnt[i] = 0;
            if (m_mode[i] == 3) begin
               if (m_pos[i] == MX) begin
                  m_st[i] = 2; m_v[i] = 0; m_b[i] = 0; m_d[i] = 1;
               end else begin
                  m_pos[i]++;
               end
            end else if (m_mode[i] == 2) begin
               m_pos[i] = (m_pos[i] + 1) % (2 * MX);
               m_w[i] = (m_pos[i] == 0) || (m_pos[i] == MX);
            end else begin
               m_pos[i] = (m_pos[i] + 1) % (MX + 1);
               m_w[i] = (m_pos[i] == 0);
            end
            if (m_st[i] == 1) m_sel[i] = sel_of(m_mode[i], m_pos[i]);
         end else begin
            m_cnt[i]++;
         end
      end else begin
         m_st[i] = 0; m_sel[i] = 0;
      end
   endtask

   function automatic logic [6:0] actual(int i);
      return {sel_o[i], valid_o[i], busy_o[i], wrap_o[i], done_o[i]};
   endfunction

   // One clock: drive inputs, queue predictions, then compare after the edge.
   task automatic cycle(input bit r, input bit s, input bit p, input logic [1:0] m);
      exp_t e;
      @(negedge clk);
      rst = r; start = s; stop = p; mode = m;
      for (int i = 0; i < NI; i++) begin
         model_step(i);
         e.inst = i;
         e.val  = {m_sel[i][2:0], m_v[i], m_b[i], m_w[i], m_d[i]};
         sb.push_back(e);
      end
      @(posedge clk);
      #1;
      cyc++;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         check($sformatf("dwell%0d_cyc%0d", DW[e.inst], cyc), 32'(actual(e.inst)), 32'(e.val));
      end
   endtask

   task automatic run_idle(int n);
      for (int k = 0; k < n; k++) cycle(0, 0, 0, 2'b00);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; stop = 1'b0; mode = 2'b00;
      for (int i = 0; i < NI; i++) model_reset(i);

      // reset state
      cycle(1, 0, 0, 2'b00);
      cycle(1, 1, 0, 2'b01);
      run_idle(2);

      // up-continuous across a full wrap
      cycle(0, 1, 0, 2'b00);
      run_idle(40);
      cycle(0, 0, 1, 2'b00);
      run_idle(2);

      // ping-pong through both turnarounds
      cycle(0, 1, 0, 2'b10);
      run_idle(60);
      cycle(0, 0, 1, 2'b00);
      run_idle(1);

      // single pass; start and mode changes mid-run must be ignored
      cycle(0, 1, 0, 2'b11);
      run_idle(5);
      cycle(0, 1, 0, 2'b01);
      run_idle(36);

      // down-continuous, then stop mid-dwell and restart
      cycle(0, 1, 0, 2'b01);
      run_idle(26);
      cycle(0, 0, 1, 2'b00);
      run_idle(1);
      cycle(0, 1, 0, 2'b00);
      run_idle(14);
      cycle(0, 0, 1, 2'b00);

      // rst during RUN with the DWELL=4 instance on code 5
      cycle(0, 1, 0, 2'b00);
      run_idle(21);
      cycle(1, 0, 0, 2'b00);
      run_idle(1);

      // start and stop together in IDLE: stop wins
      cycle(0, 1, 1, 2'b00);
      cycle(0, 1, 1, 2'b10);
      run_idle(1);

      // random stimulus
      for (int k = 0; k < 400; k++) begin
         cycle($urandom_range(0, 199) == 0,
               $urandom_range(0, 3) == 0,
               $urandom_range(0, 29) == 0,
               2'($urandom_range(0, 3)));
      end

      check("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
